sprom_rr_ctrl: RTL and testbench

//   Shares one single-port ROM (1-cycle read latency, data held while en=0) among N requesters.

---
 rtl/sprom_rr_ctrl.sv | 171 +++++++++++++++++
 tb/tb_sprom_rr_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprom_rr_ctrl.sv
// -----------------------------------------------------------------------------
// sprom_rr_ctrl
//
// Purpose:
//   Shares one single-port ROM among N requesters. The ROM has a one-cycle
//   read latency and holds its output while its enable is low. Requests
//   arrive on a valid/ready channel and are arbitrated round-robin.
//   Responses come back one at a time on a one-hot valid vector with a
//   shared data bus. This block is the only driver of the ROM enable and
//   address.
//
//   Pipeline:
//     issue  : grant, drive rom_en/rom_addr     (cycle T)
//     p1     : read in flight, ROM output valid (cycle T+1)
//     rsp    : response register, presented     (cycle T+2 earliest)
//   At most two reads are outstanding (p1 + rsp). Responses are never
//   dropped or reordered.
//
// Ports:
//   i_clk       clock
//   i_rst       asynchronous reset, active-high
//   i_req_vld   [N]    request valid, one bit per requester
//   o_req_rdy   [N]    request accepted this cycle (one-hot or zero)
//   i_req_addr  [N*A]  request addresses, requester i at [i*A +: A]
//   o_res_vld   [N]    response valid (one-hot or zero)
//   i_res_rdy   [N]    response ready, one bit per requester
//   o_res_data  [D]    response data for the requester flagged in o_res_vld
//   o_rom_en           ROM read enable
//   o_rom_addr  [A]    ROM read address
//   i_rom_data  [D]    ROM read data, valid the cycle after o_rom_en
// -----------------------------------------------------------------------------
module sprom_rr_ctrl #(
    parameter int N = 4,
    parameter int A = 6,
    parameter int D = 32
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic [N-1:0]   i_req_vld,
    output logic [N-1:0]   o_req_rdy,
    input  logic [N*A-1:0] i_req_addr,
    output logic [N-1:0]   o_res_vld,
    input  logic [N-1:0]   i_res_rdy,
    output logic [D-1:0]   o_res_data,
    output logic           o_rom_en,
    output logic [A-1:0]   o_rom_addr,
    input  logic [D-1:0]   i_rom_data
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [PW-1:0] r_ptr;       // round-robin start position
    logic          r_p1_vld;    // a ROM read is in flight
    logic [PW-1:0] r_p1_id;     // owner of the in-flight read
    logic          r_rsp_vld;   // response register holds undelivered data
    logic [PW-1:0] r_rsp_id;    // owner of the held response
    logic [D-1:0]  r_rsp_data;  // held response data

    // -------------------------------------------------------------------------
    // Pipeline flow control
    // -------------------------------------------------------------------------
    logic w_rsp_take;   // held response is consumed this cycle
    logic w_p1_adv;     // in-flight data moves into the response register
    logic w_issue_ok;   // p1 slot will be free after this edge

    assign w_rsp_take = r_rsp_vld & i_res_rdy[r_rsp_id];
    assign w_p1_adv   = r_p1_vld & (~r_rsp_vld | w_rsp_take);
    assign w_issue_ok = ~r_p1_vld | w_p1_adv;

    // -------------------------------------------------------------------------
    // Round-robin candidate ordering
    //
    // Candidate slot gi holds requester (ptr + gi) mod N. The modulo is an
    // explicit compare-and-subtract so non power-of-two N wraps correctly.
    // -------------------------------------------------------------------------
    logic [PW-1:0] w_cand_id [N];
    logic [N-1:0]  w_cand_vld;
    logic [A-1:0]  w_req_addr_arr [N];

    logic          w_found;
    logic [PW-1:0] w_gnt_id;
    logic          w_grant;
    logic [PW-1:0] w_ptr_next;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_cand
            logic [PW:0] w_sum;

            assign w_sum = {1'b0, r_ptr} + (PW+1)'(gi);
            assign w_cand_id[gi] = (w_sum >= (PW+1)'(N))
                                 ? PW'(w_sum - (PW+1)'(N))
                                 : PW'(w_sum);
            assign w_cand_vld[gi] = i_req_vld[w_cand_id[gi]];

            assign w_req_addr_arr[gi] = i_req_addr[gi*A +: A];
        end
    endgenerate

    // First valid candidate wins. Scanning from the far end downwards lets
    // the lowest-numbered slot overwrite the others without a break.
    always_comb begin
        w_found  = 1'b0;
        w_gnt_id = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_cand_vld[k]) begin
                w_found  = 1'b1;
                w_gnt_id = w_cand_id[k];
            end
        end
    end

    // The reset term keeps the ROM port quiet while reset is held, even if
    // clients keep their valids up.
    assign w_grant    = w_found & w_issue_ok & ~i_rst;
    assign w_ptr_next = (w_gnt_id == PW'(N - 1)) ? '0 : (w_gnt_id + PW'(1));

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    generate
        for (gi = 0; gi < N; gi++) begin : g_onehot
            assign o_req_rdy[gi] = w_grant & (w_gnt_id == PW'(gi));
            assign o_res_vld[gi] = r_rsp_vld & (r_rsp_id == PW'(gi));
        end
    endgenerate

    assign o_rom_en   = w_grant;
    assign o_rom_addr = w_grant ? w_req_addr_arr[w_gnt_id] : '0;

    // Data stays on the bus after delivery; only o_res_vld qualifies it.
    assign o_res_data = r_rsp_data;

    // -------------------------------------------------------------------------
    // Sequential state
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ptr      <= '0;
            r_p1_vld   <= 1'b0;
            r_p1_id    <= '0;
            r_rsp_vld  <= 1'b0;
            r_rsp_id   <= '0;
            r_rsp_data <= '0;
        end else begin
            // p1 stage: a new grant refills it, even in the same cycle the
            // previous read advances, so back-to-back issue has no bubble.
            if (w_grant) begin
                r_p1_vld <= 1'b1;
                r_p1_id  <= w_gnt_id;
                r_ptr    <= w_ptr_next;
            end else if (w_p1_adv) begin
                r_p1_vld <= 1'b0;
            end

            // Response stage: the ROM holds its output while en is low, so
            // a stalled in-flight read can be captured whenever it advances.
            if (w_p1_adv) begin
                r_rsp_vld  <= 1'b1;
                r_rsp_id   <= r_p1_id;
                r_rsp_data <= i_rom_data;
            end else if (w_rsp_take) begin
                r_rsp_vld  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sprom_rr_ctrl.sv
module tb_sprom_rr_ctrl;

    localparam int N = 4;
    localparam int A = 6;
    localparam int D = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_vld;
    logic [N-1:0]   req_rdy;
    logic [N*A-1:0] req_addr;
    logic [N-1:0]   res_vld;
    logic [N-1:0]   res_rdy;
    logic [D-1:0]   res_data;
    logic           rom_en;
    logic [A-1:0]   rom_addr;
    logic [D-1:0]   rom_data;

    int n_checks;
    int n_fail;

    always #5 clk = ~clk;

    sprom_rr_ctrl #(.N(N), .A(A), .D(D)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_req_vld  (req_vld),
        .o_req_rdy  (req_rdy),
        .i_req_addr (req_addr),
        .o_res_vld  (res_vld),
        .i_res_rdy  (res_rdy),
        .o_res_data (res_data),
        .o_rom_en   (rom_en),
        .o_rom_addr (rom_addr),
        .i_rom_data (rom_data)
    );

    // ROM contents: a distinct word per address
    function automatic logic [D-1:0] rom_val(input logic [A-1:0] a);
        return {4'h9, a, 8'hA5, ~a, 2'b01, a};
    endfunction

    logic [D-1:0] mem [64];
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = rom_val(6'(i));
    end

    // Single-port ROM: one-cycle latency, output held while en is low
    always @(posedge clk) begin
        if (rom_en) rom_data <= mem[rom_addr];
    end

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [N-1:0] v, input logic [N*A-1:0] a, input logic [N-1:0] r);
        req_vld  = v;
        req_addr = a;
        res_rdy  = r;
    endtask

    function automatic logic [A-1:0] addr_of(input logic [N*A-1:0] a, input int i);
        return a[i*A +: A];
    endfunction

    // Default addresses: req3=62, req2=33, req1=17, req0=5
    localparam logic [N*A-1:0] ADDR_DEF = {6'd62, 6'd33, 6'd17, 6'd5};
    localparam logic [N*A-1:0] ADDR_ALT = {6'd62, 6'd44, 6'd17, 6'd5};

    // -------------------------------------------------------------------------
    // Directed cycle table
    // -------------------------------------------------------------------------
    typedef struct packed {
        logic [N-1:0]   vld;
        logic [N*A-1:0] addr;
        logic [N-1:0]   rdy_in;
        logic [N-1:0]   e_rdy;
        logic           e_en;
        logic [A-1:0]   e_raddr;
        logic [N-1:0]   e_rvld;
        logic [A-1:0]   e_daddr;
        logic           e_dzero;
    } vec_t;

    localparam int NVEC = 17;
    vec_t tbl [NVEC];

    function automatic vec_t mk(input logic [N-1:0] v, input logic [N*A-1:0] a,
                                input logic [N-1:0] r, input logic [N-1:0] er,
                                input logic ee, input logic [A-1:0] ea,
                                input logic [N-1:0] ev, input logic [A-1:0] ed,
                                input logic ez);
        vec_t t;
        t.vld = v; t.addr = a; t.rdy_in = r; t.e_rdy = er; t.e_en = ee;
        t.e_raddr = ea; t.e_rvld = ev; t.e_daddr = ed; t.e_dzero = ez;
        return t;
    endfunction

    // Random-phase reference model state
    typedef struct {
        int           id;
        logic [A-1:0] addr;
        int           cyc;
    } ent_t;

    ent_t pend [$];
    int   m_ptr;
    int   wait_cnt [N];
    int   n_grants;
    int   n_resps;

    initial begin
        logic [N-1:0]   v;
        logic [N-1:0]   r;
        logic [N*A-1:0] a;
        int             g;
        int             idx;
        int             take;
        logic [N-1:0]   e_rdy;
        logic [N-1:0]   e_rvld;
        logic [A-1:0]   e_raddr;

        n_checks = 0;
        n_fail   = 0;

        // Single request (0), pointer walk (5..8), stall with ignored
        // non-addressed ready (9..13), address sampled at grant (13).
        tbl[0]  = mk(4'b0000, ADDR_DEF, 4'hF, 4'b0000, 0, 0,  4'b0000, 0,  1);
        tbl[1]  = mk(4'b0001, ADDR_DEF, 4'hF, 4'b0001, 1, 5,  4'b0000, 0,  1);
        tbl[2]  = mk(4'b0000, ADDR_DEF, 4'hF, 4'b0000, 0, 0,  4'b0000, 0,  1);
        tbl[3]  = mk(4'b0000, ADDR_DEF, 4'hF, 4'b0000, 0, 0,  4'b0001, 5,  0);
        tbl[4]  = mk(4'b0000, ADDR_DEF, 4'hF, 4'b0000, 0, 0,  4'b0000, 5,  0);
        tbl[5]  = mk(4'b0010, ADDR_DEF, 4'hF, 4'b0010, 1, 17, 4'b0000, 5,  0);
        tbl[6]  = mk(4'b1001, ADDR_DEF, 4'hF, 4'b1000, 1, 62, 4'b0000, 5,  0);
        tbl[7]  = mk(4'b1001, ADDR_DEF, 4'hF, 4'b0001, 1, 5,  4'b0010, 17, 0);
        tbl[8]  = mk(4'b0000, ADDR_DEF, 4'hF, 4'b0000, 0, 0,  4'b1000, 62, 0);
        tbl[9]  = mk(4'b0000, ADDR_DEF, 4'h0, 4'b0000, 0, 0,  4'b0001, 5,  0);
        tbl[10] = mk(4'b0100, ADDR_DEF, 4'h0, 4'b0100, 1, 33, 4'b0001, 5,  0);
        tbl[11] = mk(4'b0100, ADDR_DEF, 4'h0, 4'b0000, 0, 0,  4'b0001, 5,  0);
        tbl[12] = mk(4'b0100, ADDR_DEF, 4'hE, 4'b0000, 0, 0,  4'b0001, 5,  0);
        tbl[13] = mk(4'b0100, ADDR_ALT, 4'h1, 4'b0100, 1, 44, 4'b0001, 5,  0);
        tbl[14] = mk(4'b0000, ADDR_DEF, 4'hF, 4'b0000, 0, 0,  4'b0100, 33, 0);
        tbl[15] = mk(4'b0000, ADDR_DEF, 4'hF, 4'b0000, 0, 0,  4'b0100, 44, 0);
        tbl[16] = mk(4'b0000, ADDR_DEF, 4'hF, 4'b0000, 0, 0,  4'b0000, 44, 0);

        rst = 1'b1;
        drive('0, ADDR_DEF, '0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // ---------------------------------------------------------------------
        // Table-driven directed cycles
        // ---------------------------------------------------------------------
        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i].vld, tbl[i].addr, tbl[i].rdy_in);
            #3;
            chk($sformatf("tbl%0d.req_rdy", i),  64'(req_rdy),  64'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d.rom_en", i),   64'(rom_en),   64'(tbl[i].e_en));
            chk($sformatf("tbl%0d.rom_addr", i), 64'(rom_addr), 64'(tbl[i].e_raddr));
            chk($sformatf("tbl%0d.res_vld", i),  64'(res_vld),  64'(tbl[i].e_rvld));
            if (tbl[i].e_dzero)
                chk($sformatf("tbl%0d.res_data", i), 64'(res_data), 64'(0));
            else
                chk($sformatf("tbl%0d.res_data", i), 64'(res_data), 64'(rom_val(tbl[i].e_daddr)));
            $display("tbl[%0d] req_vld=%b req_rdy=%b rom_en=%b rom_addr=%0d res_vld=%b res_data=%h",
                     i, req_vld, req_rdy, rom_en, rom_addr, res_vld, res_data);
            step();
        end

        // ---------------------------------------------------------------------
        // Asynchronous reset with a read in flight (pointer is at 3 here)
        // ---------------------------------------------------------------------
        drive(4'b0001, ADDR_DEF, 4'hF);
        #3;
        chk("rstmid.grant", 64'(req_rdy), 64'(4'b0001));
        chk("rstmid.rom_en_T", 64'(rom_en), 64'(1));
        step();
        drive('0, ADDR_DEF, 4'hF);
        #1;
        rst = 1'b1;
        #1;
        chk("rstmid.res_vld", 64'(res_vld), 64'(0));
        chk("rstmid.rom_en", 64'(rom_en), 64'(0));
        chk("rstmid.req_rdy", 64'(req_rdy), 64'(0));
        chk("rstmid.res_data", 64'(res_data), 64'(0));
        $display("rstmid: reset asserted res_vld=%b rom_en=%b", res_vld, rom_en);
        step();
        step();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive('0, ADDR_DEF, 4'hF);
            #3;
            chk($sformatf("rstmid.stale%0d", k), 64'(res_vld), 64'(0));
            step();
        end

        // ---------------------------------------------------------------------
        // Fairness: all requesting, all ready; pointer restarts at 0
        // ---------------------------------------------------------------------
        for (int k = 0; k < 10; k++) begin
            drive((k < 8) ? 4'hF : 4'h0, ADDR_DEF, 4'hF);
            #3;
            chk($sformatf("fair%0d.req_rdy", k), 64'(req_rdy),
                (k < 8) ? 64'(1 << (k % 4)) : 64'(0));
            chk($sformatf("fair%0d.rom_addr", k), 64'(rom_addr),
                (k < 8) ? 64'(addr_of(ADDR_DEF, k % 4)) : 64'(0));
            chk($sformatf("fair%0d.res_vld", k), 64'(res_vld),
                (k >= 2) ? 64'(1 << ((k - 2) % 4)) : 64'(0));
            if (k >= 2)
                chk($sformatf("fair%0d.res_data", k), 64'(res_data),
                    64'(rom_val(addr_of(ADDR_DEF, (k - 2) % 4))));
            $display("fair[%0d] req_rdy=%b rom_addr=%0d res_vld=%b res_data=%h",
                     k, req_rdy, rom_addr, res_vld, res_data);
            step();
        end

        // ---------------------------------------------------------------------
        // Backpressure: two back-to-back reads, 5 stalled cycles, release
        // ---------------------------------------------------------------------
        for (int j = 0; j < 10; j++) begin
            if (j == 0)      drive(4'b0001, ADDR_DEF, 4'h0);
            else if (j == 1) drive(4'b0010, ADDR_DEF, 4'h0);
            else if (j < 7)  drive(4'b0100, ADDR_DEF, 4'h0);
            else             drive(4'b0000, ADDR_DEF, 4'hF);
            #3;
            e_rdy  = (j == 0) ? 4'b0001 : (j == 1) ? 4'b0010 : 4'b0000;
            e_rvld = (j >= 2 && j <= 7) ? 4'b0001 : (j == 8) ? 4'b0010 : 4'b0000;
            chk($sformatf("bp%0d.req_rdy", j), 64'(req_rdy), 64'(e_rdy));
            chk($sformatf("bp%0d.rom_en", j), 64'(rom_en), 64'(j < 2));
            chk($sformatf("bp%0d.res_vld", j), 64'(res_vld), 64'(e_rvld));
            if (j >= 2 && j <= 7)
                chk($sformatf("bp%0d.res_data", j), 64'(res_data), 64'(rom_val(6'd5)));
            else if (j == 8)
                chk($sformatf("bp%0d.res_data", j), 64'(res_data), 64'(rom_val(6'd17)));
            $display("bp[%0d] req_rdy=%b rom_en=%b res_vld=%b res_data=%h",
                     j, req_rdy, rom_en, res_vld, res_data);
            step();
        end

        // ---------------------------------------------------------------------
        // Random traffic against a transaction-level model:
        //   - reads complete in issue order, at most two outstanding
        //   - the oldest read is presented once it is two cycles old
        //   - a new read may issue if fewer than two remain after delivery
        //   - round-robin start rotates past the last winner
        // ---------------------------------------------------------------------
        rst = 1'b1;
        drive('0, ADDR_DEF, '0);
        step();
        step();
        rst = 1'b0;
        pend.delete();
        m_ptr    = 0;
        n_grants = 0;
        n_resps  = 0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;

        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                v[i] = ($urandom_range(0, 99) < 60);
                r[i] = ($urandom_range(0, 99) < 70);
            end
            a = (N*A)'($urandom);
            drive(v, a, r);
            #3;

            e_rvld = '0;
            take   = 0;
            if (pend.size() > 0 && pend[0].cyc <= cyc - 2) begin
                e_rvld[pend[0].id] = 1'b1;
                chk("rnd.res_data", 64'(res_data), 64'(rom_val(pend[0].addr)));
                take = r[pend[0].id] ? 1 : 0;
            end
            chk("rnd.res_vld", 64'(res_vld), 64'(e_rvld));

            g = -1;
            if (pend.size() - take < 2) begin
                for (int k = N - 1; k >= 0; k--) begin
                    idx = (m_ptr + k) % N;
                    if (v[idx]) g = idx;
                end
            end
            e_rdy   = '0;
            e_raddr = '0;
            if (g >= 0) begin
                e_rdy[g] = 1'b1;
                e_raddr  = addr_of(a, g);
            end
            chk("rnd.req_rdy", 64'(req_rdy), 64'(e_rdy));
            chk("rnd.rom_en", 64'(rom_en), 64'(g >= 0));
            chk("rnd.rom_addr", 64'(rom_addr), 64'(e_raddr));

            if (take != 0) begin
                void'(pend.pop_front());
                n_resps++;
            end
            if (g >= 0) begin
                pend.push_back('{id: g, addr: addr_of(a, g), cyc: cyc});
                m_ptr = (g + 1) % N;
                n_grants++;
                for (int i = 0; i < N; i++) begin
                    if (i == g) begin
                        chk("rnd.starvation", 64'(wait_cnt[i] <= N - 1), 64'(1));
                        wait_cnt[i] = 0;
                    end else if (v[i]) begin
                        wait_cnt[i]++;
                    end
                end
            end
            for (int i = 0; i < N; i++) begin
                if (!v[i]) wait_cnt[i] = 0;
            end
            step();
        end
        $display("random: %0d grants, %0d responses delivered", n_grants, n_resps);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
